// File: rtl/qsn_pkg.sv
// Shared parameters, lane type and shift helpers for the Pc=5 inverse QSN.
package qsn_pkg;

    localparam int PC      = 5;
    localparam int QB      = 3;
    localparam int SHIFT_W = 3;

    typedef logic [QB-1:0] msg_lane_t;

    // Rotation that undoes a forward shift of s lanes.
    function automatic logic [SHIFT_W-1:0] inv_shift(input logic [SHIFT_W-1:0] s);
        return SHIFT_W'((PC - int'(s)) % PC);
    endfunction

    // Bit j set: output lane j comes from the non-wrapped (left) copy.
    function automatic logic [PC-2:0] sel_mask(input logic [SHIFT_W-1:0] s);
        logic [PC-2:0] m;
        for (int j = 0; j < PC - 1; j++) begin
            m[j] = (j >= int'(s));
        end
        return m;
    endfunction

    function automatic logic [SHIFT_W-1:0] rot_idx(input int base, input logic [SHIFT_W-1:0] s);
        return SHIFT_W'((base + int'(s)) % PC);
    endfunction

endpackage

// File: rtl/qsn_unshift_pc5_if.sv
// Stream bundle for the inverse QSN: input lanes/shift, output lanes, error flag.
interface qsn_unshift_pc5_if;
    import qsn_pkg::*;

    logic [PC*QB-1:0]   msg_in;
    logic [SHIFT_W-1:0] shift_in;
    logic               in_valid;
    logic               in_ready;
    logic [PC*QB-1:0]   msg_out;
    logic               out_valid;
    logic               out_ready;
    logic               shift_err;

    modport slave (
        input  msg_in, shift_in, in_valid, out_ready,
        output in_ready, msg_out, out_valid, shift_err
    );

    modport master (
        output msg_in, shift_in, in_valid, out_ready,
        input  in_ready, msg_out, out_valid, shift_err
    );

endinterface

// File: rtl/qsn_unmerge_len5.sv
// One bit plane of the stage-2 merge: pick the left copy or the mirrored right copy per lane.
module qsn_unmerge_len5 (
    input  logic [3:0] left,
    input  logic [4:0] right,
    input  logic [3:0] sel,
    output logic [4:0] out
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign out[gi] = sel[gi] ? left[gi] : right[4-gi];
    end

    assign out[4] = right[0];

endmodule

// File: rtl/qsn_unshift_pc5.sv
// Two-stage inverse QSN: stage 1 registers the split copies, stage 2 merges per lane.
module qsn_unshift_pc5
    import qsn_pkg::*;
(
    input  logic               sys_clk,
    input  logic               rstn,
    qsn_unshift_pc5_if.slave   bus
);

    logic               s1_adv;
    logic               s2_adv;
    logic               in_xfer;
    logic               shift_bad;
    logic [SHIFT_W-1:0] s_eff;
    logic [SHIFT_W-1:0] s_inv;

    msg_lane_t          in_lane    [PC];
    msg_lane_t          left_next  [PC-1];
    msg_lane_t          right_next [PC];
    msg_lane_t          left_reg   [PC-1];
    msg_lane_t          right_reg  [PC];
    logic [PC-2:0]      sel_reg;
    logic               s1_valid_reg;
    logic               s2_valid_reg;
    logic               shift_err_reg;
    logic [PC*QB-1:0]   msg_out_reg;
    logic [PC*QB-1:0]   merged_next;
    logic [PC-1:0]      plane_out  [QB];

    assign s2_adv  = !s2_valid_reg || bus.out_ready;
    assign s1_adv  = !s1_valid_reg || s2_adv;
    assign in_xfer = bus.in_valid && s1_adv;

    // Illegal shifts fall back to passthrough.
    assign shift_bad = (bus.shift_in >= SHIFT_W'(PC));
    assign s_eff     = shift_bad ? '0 : bus.shift_in;
    assign s_inv     = inv_shift(s_eff);

    for (genvar gi = 0; gi < PC; gi++) begin : g_in
        assign in_lane[gi] = bus.msg_in[gi*QB +: QB];
    end

    // Left copy is the plain rotation; right copy is the same rotation stored mirrored,
    // so right[0] always feeds the top lane and right[PC-1-j] covers wrapped lanes.
    for (genvar gi = 0; gi < PC - 1; gi++) begin : g_left
        assign left_next[gi] = in_lane[rot_idx(gi, s_inv)];
    end

    for (genvar gi = 0; gi < PC; gi++) begin : g_right
        assign right_next[gi] = in_lane[rot_idx(PC - 1 - gi, s_inv)];
    end

    always_ff @(posedge sys_clk) begin
        if (in_xfer) begin
            left_reg  <= left_next;
            right_reg <= right_next;
            sel_reg   <= sel_mask(s_eff);
        end
    end

    for (genvar gi = 0; gi < QB; gi++) begin : g_plane
        logic [PC-2:0] left_bits;
        logic [PC-1:0] right_bits;

        for (genvar gj = 0; gj < PC - 1; gj++) begin : g_lb
            assign left_bits[gj] = left_reg[gj][gi];
        end
        for (genvar gj = 0; gj < PC; gj++) begin : g_rb
            assign right_bits[gj] = right_reg[gj][gi];
        end

        qsn_unmerge_len5 u_merge (
            .left  (left_bits),
            .right (right_bits),
            .sel   (sel_reg),
            .out   (plane_out[gi])
        );
    end

    for (genvar gi = 0; gi < PC; gi++) begin : g_pack
        for (genvar gj = 0; gj < QB; gj++) begin : g_bit
            assign merged_next[gi*QB + gj] = plane_out[gj][gi];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            msg_out_reg   <= '0;
            shift_err_reg <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= bus.in_valid;
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s2_adv && s1_valid_reg) begin
                msg_out_reg <= merged_next;
            end
            if (in_xfer && shift_bad) begin
                shift_err_reg <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.msg_out   = msg_out_reg;
    assign bus.out_valid = s2_valid_reg;
    assign bus.shift_err = shift_err_reg;

endmodule

// File: tb/tb_qsn_unshift_pc5.sv
// Scoreboard bench for qsn_unshift_pc5: directed vectors, stalls, reset and random handshakes.
module tb_qsn_unshift_pc5;
    import qsn_pkg::*;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;

    qsn_unshift_pc5_if bus ();

    qsn_unshift_pc5 dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [14:0] msg;
        logic [2:0]  s;
        logic [14:0] exp;
        bit          has_exp;
        bit          chk_lat;
        int          acc_cyc;
    } entry_t;

    entry_t      sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          cyc   = 0;
    logic [14:0] cur_exp;
    bit          cur_has;
    bit          cur_lat;
    bit          done;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Forward QSN: out[i] = in[(i + s) mod 5], illegal shifts pass through.
    function automatic logic [14:0] fwd(input logic [14:0] m, input logic [2:0] s);
        int          se;
        logic [14:0] r;
        se = (s >= 3'd5) ? 0 : int'(s);
        for (int i = 0; i < 5; i++) begin
            r[i*3 +: 3] = m[((i + se) % 5)*3 +: 3];
        end
        return r;
    endfunction

    // Input sniffer: every accepted transfer becomes a scoreboard entry.
    initial forever begin
        @(negedge sys_clk);
        if (rstn && bus.in_valid && bus.in_ready) begin
            entry_t e;
            e.msg     = bus.msg_in;
            e.s       = bus.shift_in;
            e.exp     = cur_exp;
            e.has_exp = cur_has;
            e.chk_lat = cur_lat;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    end

    // Output monitor.
    initial begin
        bit          stall_prev;
        logic [14:0] prev_msg;
        entry_t      e;
        stall_prev = 1'b0;
        prev_msg   = '0;
        forever begin
            @(negedge sys_clk);
            if (!rstn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_msg_out", bus.msg_out, prev_msg);
                    chk("hold_out_valid", bus.out_valid, 1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", bus.msg_out, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        n_out++;
                        if (e.has_exp) chk("lane_value", bus.msg_out, e.exp);
                        chk("roundtrip", fwd(bus.msg_out, e.s), e.msg);
                        if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 2);
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                prev_msg   = bus.msg_out;
            end
        end
    end

    task automatic send(input logic [14:0] m, input logic [2:0] s, input logic [14:0] e,
                        input bit has, input bit lat, input bit nostall);
        int w;
        @(posedge sys_clk);
        #1;
        bus.msg_in   = m;
        bus.shift_in = s;
        bus.in_valid = 1'b1;
        cur_exp      = e;
        cur_has      = has;
        cur_lat      = lat;
        w = 0;
        @(negedge sys_clk);
        while (!bus.in_ready && w < 1000) begin
            w++;
            @(negedge sys_clk);
        end
        if (!bus.in_ready) chk("send_timeout", 0, 1);
        if (nostall) chk("stream_wait_cycles", w, 0);
    endtask

    task automatic idle();
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        @(posedge sys_clk);
        #1;
        bus.out_ready = 1'b1;
        w = 0;
        @(negedge sys_clk);
        while ((sb.size() != 0 || bus.out_valid) && w < 200) begin
            w++;
            @(negedge sys_clk);
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] va, vb, m;
        logic [14:0] vin  [7];
        logic [2:0]  vs   [7];
        logic [14:0] vexp [7];
        int          out_base;

        // Lane k = k, and a second pattern {7,6,5,1,2}; expected values worked by hand.
        va = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vb = {3'd2, 3'd1, 3'd5, 3'd6, 3'd7};
        vin[0] = va; vs[0] = 3'd2; vexp[0] = {3'd2, 3'd1, 3'd0, 3'd4, 3'd3};
        vin[1] = va; vs[1] = 3'd0; vexp[1] = va;
        vin[2] = va; vs[2] = 3'd1; vexp[2] = {3'd3, 3'd2, 3'd1, 3'd0, 3'd4};
        vin[3] = va; vs[3] = 3'd3; vexp[3] = {3'd1, 3'd0, 3'd4, 3'd3, 3'd2};
        vin[4] = va; vs[4] = 3'd4; vexp[4] = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
        vin[5] = vb; vs[5] = 3'd3; vexp[5] = {3'd6, 3'd7, 3'd2, 3'd1, 3'd5};
        vin[6] = vb; vs[6] = 3'd1; vexp[6] = {3'd1, 3'd5, 3'd6, 3'd7, 3'd2};

        bus.msg_in    = '0;
        bus.shift_in  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        done          = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 rstn = 1'b1;
        @(negedge sys_clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_msg_out", bus.msg_out, 0);
        chk("reset_shift_err", bus.shift_err, 0);
        chk("reset_in_ready", bus.in_ready, 1);

        // Directed vectors, streamed back to back with out_ready high.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(vin[i], vs[i], vexp[i], 1, 1, 1);
        idle();
        drain();
        chk("shift_err_clean", bus.shift_err, 0);

        // Shift sweep with random data, round-trip checked; s=0 must be exact.
        for (int s = 0; s < 5; s++) begin
            m = 15'($urandom);
            send(m, 3'(s), m, (s == 0), 1, 1);
        end
        idle();
        drain();

        // Eight back-to-back inputs with out_ready low for cycles 3..6.
        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(15'($urandom), 3'($urandom_range(0, 4)), '0, 0, 0, 0);
                idle();
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(posedge sys_clk);
                    #1 bus.out_ready = !(c >= 3 && c <= 6);
                    if (c == 6) begin
                        @(negedge sys_clk);
                        chk("stall_in_ready", bus.in_ready, 0);
                        chk("stall_out_valid", bus.out_valid, 1);
                    end
                end
            end
        join
        drain();
        chk("stall_output_count", n_out - out_base, 8);

        // Illegal shifts pass through and latch shift_err.
        send(va, 3'd5, va, 1, 1, 1);
        idle();
        drain();
        chk("shift_err_set", bus.shift_err, 1);
        send(vb, 3'd7, vb, 1, 1, 1);
        send(vb, 3'd3, vexp[5], 1, 1, 1);
        send(va, 3'd2, vexp[0], 1, 1, 1);
        idle();
        drain();
        chk("shift_err_sticky", bus.shift_err, 1);

        // Fill both stages under back-pressure, then reset mid-stream.
        @(posedge sys_clk);
        #1 bus.out_ready = 1'b0;
        send(vb, 3'd1, vexp[6], 1, 0, 0);
        send(va, 3'd4, vexp[4], 1, 0, 0);
        idle();
        @(negedge sys_clk);
        chk("pre_reset_full", bus.out_valid, 1);
        chk("pre_reset_in_ready", bus.in_ready, 0);
        @(posedge sys_clk);
        #1 rstn = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_msg_out", bus.msg_out, 0);
        chk("midreset_shift_err", bus.shift_err, 0);
        sb.delete();
        @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge sys_clk);
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_out_valid", bus.out_valid, 0);
        send(va, 3'd3, vexp[3], 1, 1, 1);
        idle();
        drain();

        // Random valid/ready traffic.
        out_base = n_out;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    if ($urandom_range(0, 15) == 0)
                        send(15'($urandom), 3'($urandom_range(5, 7)), '0, 0, 0, 0);
                    else
                        send(15'($urandom), 3'($urandom_range(0, 4)), '0, 0, 0, 0);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge sys_clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        chk("random_output_count", n_out - out_base, 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
